// File: rtl/button_repeat_if.sv
`default_nettype none
// ============================================================================
// button_repeat_if : button levels / tick enable in, strobes and levels out
// Revision 1.0
// ============================================================================
interface button_repeat_if #(
    parameter int CHANNELS = 3
);
    logic                clk_en;
    logic [CHANNELS-1:0] buttons;
    logic [CHANNELS-1:0] pulse;
    logic [CHANNELS-1:0] held;
    logic [CHANNELS-1:0] repeating;

    modport master (
        output clk_en,
        output buttons,
        input  pulse,
        input  held,
        input  repeating
    );

    modport slave (
        input  clk_en,
        input  buttons,
        output pulse,
        output held,
        output repeating
    );
endinterface
`default_nettype wire

// File: rtl/button_repeat.sv
`default_nettype none
// ============================================================================
// button_repeat : per-channel sync, debounce and accelerating auto-repeat
// Revision 1.0
// ============================================================================
module button_repeat #(
    parameter int                  CHANNELS    = 3,
    parameter int                  SYNC_STAGES = 2,
    parameter int                  DEBOUNCE    = 4,
    parameter int                  FIRST_DELAY = 16,
    parameter int                  MAX_COUNT   = 8,
    parameter int                  DEC_COUNT   = 2,
    parameter int                  MIN_COUNT   = 1,
    parameter logic [CHANNELS-1:0] REPEAT_MASK = '1
) (
    input  wire logic      clk,
    input  wire logic      reset_n,
    button_repeat_if.slave bus
);
    localparam int c_SPAN = (FIRST_DELAY > MAX_COUNT) ? FIRST_DELAY : MAX_COUNT;
    localparam int c_CW   = $clog2(c_SPAN + 1);
    localparam int c_DW   = $clog2(DEBOUNCE + 1);

    localparam logic [c_CW-1:0] c_COMP_INIT = c_CW'(MAX_COUNT - 1);
    localparam logic [c_CW-1:0] c_FD_LAST   = c_CW'(FIRST_DELAY - 1);
    localparam logic [c_CW-1:0] c_DEC       = c_CW'(DEC_COUNT);
    localparam logic [c_CW-1:0] c_MIN       = c_CW'(MIN_COUNT);
    localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEBOUNCE - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DELAY  = 2'd1;
    localparam logic [1:0] c_HOLD   = 2'd2;
    localparam logic [1:0] c_REPEAT = 2'd3;

    logic [CHANNELS-1:0] w_pulse;
    logic [CHANNELS-1:0] w_held;
    logic [CHANNELS-1:0] w_repeating;

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_ch
            logic [SYNC_STAGES-1:0] sync_q;
            logic [c_DW-1:0]        deb_q, deb_d;
            logic                   held_q, held_d;
            logic [1:0]             state_q, state_d;
            logic [c_CW-1:0]        count_q, count_d;
            logic [c_CW-1:0]        comp_q, comp_d;
            logic                   pulse_q, pulse_d;
            logic                   rep_q, rep_d;
            logic                   w_s;
            logic                   w_rise;
            logic                   w_fall;
            logic                   w_comp_dec_ok;

            assign w_s           = sync_q[SYNC_STAGES-1];
            assign w_rise        = held_d & ~held_q;
            assign w_fall        = held_q & ~held_d;
            assign w_comp_dec_ok = 32'(comp_q) >= MIN_COUNT + DEC_COUNT;

            // The synchroniser runs on every clk, independent of the tick.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= '0;
                end else begin
                    sync_q <= {sync_q[SYNC_STAGES-2:0], bus.buttons[i]};
                end
            end

            always_comb begin
                deb_d  = deb_q;
                held_d = held_q;
                if (bus.clk_en) begin
                    if (w_s != held_q) begin
                        if (deb_q == c_DEB_LAST) begin
                            deb_d  = '0;
                            held_d = ~held_q;
                        end else begin
                            deb_d = deb_q + c_DW'(1);
                        end
                    end else begin
                        deb_d = '0;
                    end
                end
            end

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    deb_q   <= '0;
                    held_q  <= 1'b0;
                    state_q <= c_IDLE;
                    count_q <= '0;
                    comp_q  <= c_COMP_INIT;
                    pulse_q <= 1'b0;
                    rep_q   <= 1'b0;
                end else begin
                    deb_q   <= deb_d;
                    held_q  <= held_d;
                    state_q <= state_d;
                    count_q <= count_d;
                    comp_q  <= comp_d;
                    pulse_q <= pulse_d;
                    rep_q   <= rep_d;
                end
            end

            // A falling debounced level overrides any pulse due on the same tick.
            always_comb begin
                state_d = state_q;
                count_d = count_q;
                comp_d  = comp_q;
                if (w_fall) begin
                    state_d = c_IDLE;
                    count_d = '0;
                    comp_d  = c_COMP_INIT;
                end else if (bus.clk_en) begin
                    case (state_q)
                        c_IDLE: begin
                            if (w_rise) begin
                                count_d = '0;
                                comp_d  = c_COMP_INIT;
                                state_d = REPEAT_MASK[i] ? c_DELAY : c_HOLD;
                            end
                        end
                        c_DELAY: begin
                            if (count_q == c_FD_LAST) begin
                                count_d = '0;
                                state_d = c_REPEAT;
                            end else begin
                                count_d = count_q + c_CW'(1);
                            end
                        end
                        c_REPEAT: begin
                            if (count_q == comp_q) begin
                                count_d = '0;
                                comp_d  = w_comp_dec_ok ? (comp_q - c_DEC) : c_MIN;
                            end else begin
                                count_d = count_q + c_CW'(1);
                            end
                        end
                        c_HOLD: begin
                        end
                        default: begin
                            state_d = c_IDLE;
                        end
                    endcase
                end
            end

            always_comb begin
                pulse_d = 1'b0;
                if (bus.clk_en && !w_fall) begin
                    pulse_d = ((state_q == c_IDLE)   && w_rise) ||
                              ((state_q == c_DELAY)  && (count_q == c_FD_LAST)) ||
                              ((state_q == c_REPEAT) && (count_q == comp_q));
                end
                rep_d = (state_d == c_REPEAT);
            end

            assign w_pulse[i]     = pulse_q;
            assign w_held[i]      = held_q;
            assign w_repeating[i] = rep_q;
        end
    endgenerate

    assign bus.pulse     = w_pulse;
    assign bus.held      = w_held;
    assign bus.repeating = w_repeating;
endmodule
`default_nettype wire

// File: tb/tb_button_repeat.sv
`default_nettype none
// ============================================================================
// tb_button_repeat : directed + random stimulus against a schedule-level model
// Revision 1.0
// ============================================================================
module tb_button_repeat;
    localparam int CH   = 3;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int FD   = 16;
    localparam int MAXC = 8;
    localparam int DEC  = 2;
    localparam int MINC = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b1;
    logic [CH-1:0] btn = '0;
    int            en_div = 1;
    int            cyc_n = 0;
    int            checks = 0;
    int            errors = 0;

    button_repeat_if #(.CHANNELS(CH)) ifa ();
    button_repeat_if #(.CHANNELS(CH)) ifb ();

    assign ifa.clk_en  = en;
    assign ifa.buttons = btn;
    assign ifb.clk_en  = en;
    assign ifb.buttons = btn;

    button_repeat #(.CHANNELS(CH)) dut_a (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (ifa)
    );

    button_repeat #(.CHANNELS(CH), .REPEAT_MASK(3'b101)) dut_b (
        .clk     (clk),
        .reset_n (rst_n),
        .bus     (ifb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Model: index 0 = all channels repeat, index 1 = channel 1 single-shot.
    bit [SYNC-1:0] m_sync   [2][CH];
    int            m_run    [2][CH];
    bit            m_held   [2][CH];
    bit            m_rep    [2][CH];
    bit            m_pulse  [2][CH];
    bit            m_active [2][CH];
    int            m_t      [2][CH];
    int            m_due    [2][CH];
    int            m_int    [2][CH];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CH; c++) begin
                    m_sync[d][c]   = '0;
                    m_run[d][c]    = 0;
                    m_held[d][c]   = 1'b0;
                    m_rep[d][c]    = 1'b0;
                    m_pulse[d][c]  = 1'b0;
                    m_active[d][c] = 1'b0;
                    m_t[d][c]      = 0;
                    m_due[d][c]    = 0;
                    m_int[d][c]    = 0;
                end
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int c = 0; c < CH; c++) begin
                    bit s;
                    bit ev;
                    s  = m_sync[d][c][SYNC-1];
                    ev = 1'b0;
                    m_sync[d][c]  = {m_sync[d][c][SYNC-2:0], btn[c]};
                    m_pulse[d][c] = 1'b0;
                    if (en) begin
                        if (s != m_held[d][c]) begin
                            m_run[d][c]++;
                            if (m_run[d][c] == DEB) begin
                                ev           = 1'b1;
                                m_run[d][c]  = 0;
                                m_held[d][c] = s;
                                if (s) begin
                                    m_pulse[d][c]  = 1'b1;
                                    m_t[d][c]      = 0;
                                    m_due[d][c]    = FD;
                                    m_int[d][c]    = MAXC;
                                    m_active[d][c] = (d == 0) || (c != 1);
                                end else begin
                                    m_active[d][c] = 1'b0;
                                    m_rep[d][c]    = 1'b0;
                                end
                            end
                        end else begin
                            m_run[d][c] = 0;
                        end
                        if (!ev && m_active[d][c]) begin
                            m_t[d][c]++;
                            if (m_t[d][c] == m_due[d][c]) begin
                                m_pulse[d][c] = 1'b1;
                                m_rep[d][c]   = 1'b1;
                                m_due[d][c]   = m_due[d][c] + m_int[d][c];
                                m_int[d][c]   = (m_int[d][c] - DEC > MINC + 1) ? m_int[d][c] - DEC : MINC + 1;
                            end
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            logic [CH-1:0] ep, eh, er, ap, ah, ar;
            for (int c = 0; c < CH; c++) begin
                ep[c] = m_pulse[d][c];
                eh[c] = m_held[d][c];
                er[c] = m_rep[d][c];
            end
            ap = (d == 0) ? ifa.pulse     : ifb.pulse;
            ah = (d == 0) ? ifa.held      : ifb.held;
            ar = (d == 0) ? ifa.repeating : ifb.repeating;
            checks++;
            if ({ap, ah, ar} !== {ep, eh, er}) begin
                errors++;
                $display("FAIL model_cmp dut%0d t=%0t pulse/held/repeating actual=%b/%b/%b required=%b/%b/%b",
                         d, $time, ap, ah, ar, ep, eh, er);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
        if (en_div == 0) en = ($urandom_range(0, 3) != 0);
        else             en = ((cyc_n % en_div) == 0);
        cyc_n++;
    endtask

    int edges[$];
    int cnt_a[CH];
    int cnt_b[CH];
    int first;

    initial begin
        // reset held, then released with buttons low
        repeat (3) cyc();
        check("rst_pulse", int'(ifa.pulse), 0);
        check("rst_held", int'(ifa.held), 0);
        check("rst_repeating", int'(ifa.repeating), 0);
        rst_n = 1'b1;
        first = 0;
        repeat (100) begin
            cyc();
            first += int'(|{ifa.pulse, ifa.held, ifa.repeating, ifb.pulse, ifb.held, ifb.repeating});
        end
        check("idle_after_reset_activity", first, 0);

        // channel 0 held 50 cycles: pulse schedule
        btn = 3'b001;
        edges.delete();
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (ifa.pulse[0]) edges.push_back(k);
        end
        check("sched_count_ch0", edges.size(), 10);
        if (edges.size() >= 7) begin
            check("sched_e0", edges[0], 5);
            check("sched_e1", edges[1], 21);
            check("sched_e2", edges[2], 29);
            check("sched_e3", edges[3], 35);
            check("sched_e4", edges[4], 39);
            check("sched_e5", edges[5], 41);
            check("sched_e6", edges[6], 43);
        end
        btn = '0;
        repeat (20) cyc();

        // bounce on channel 1
        first = 0;
        for (int k = 0; k < 40; k++) begin
            if (k % 2 == 0) btn[1] = ~btn[1];
            cyc();
            first += int'(ifa.pulse[1]) + int'(ifb.pulse[1]);
        end
        btn = '0;
        repeat (20) cyc();
        check("bounce_pulses", first, 0);
        check("bounce_held1", int'(ifa.held[1]), 0);

        // all buttons held 60 cycles, DUT B has channel 1 single-shot
        for (int c = 0; c < CH; c++) begin
            cnt_a[c] = 0;
            cnt_b[c] = 0;
        end
        btn = 3'b111;
        repeat (60) begin
            cyc();
            for (int c = 0; c < CH; c++) begin
                cnt_a[c] += int'(ifa.pulse[c]);
                cnt_b[c] += int'(ifb.pulse[c]);
            end
        end
        check("mask_a_ch1", cnt_a[1], 15);
        check("mask_b_ch0", cnt_b[0], 15);
        check("mask_b_ch1", cnt_b[1], 1);
        check("mask_b_ch2", cnt_b[2], 15);
        check("mask_b_rep1", int'(ifb.repeating[1]), 0);
        btn = '0;
        repeat (20) cyc();

        // tap then re-press
        first = 0;
        btn[0] = 1'b1;
        repeat (10) begin cyc(); first += int'(ifa.pulse[0]); end
        btn[0] = 1'b0;
        repeat (20) begin cyc(); first += int'(ifa.pulse[0]); end
        check("tap_pulses", first, 1);
        btn[0] = 1'b1;
        edges.delete();
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (ifa.pulse[0]) edges.push_back(k);
        end
        check("repress_count", edges.size(), 3);
        if (edges.size() >= 3) begin
            check("repress_e0", edges[0], 5);
            check("repress_e1", edges[1], 21);
            check("repress_e2", edges[2], 29);
        end
        btn = '0;
        repeat (20) cyc();

        // clk_en every 4th cycle: intervals scale by 4
        en_div = 4;
        cyc_n  = 0;
        btn[2] = 1'b1;
        edges.delete();
        for (int k = 0; k < 180; k++) begin
            cyc();
            if (ifa.pulse[2]) edges.push_back(k);
        end
        check("slow_count_ge5", int'(edges.size() >= 5), 1);
        if (edges.size() >= 5) begin
            check("slow_d0", edges[1] - edges[0], 64);
            check("slow_d1", edges[2] - edges[1], 32);
            check("slow_d2", edges[3] - edges[2], 24);
            check("slow_d3", edges[4] - edges[3], 16);
        end
        btn = '0;
        en_div = 1;
        repeat (40) cyc();

        // asynchronous reset in the middle of REPEAT
        btn = 3'b111;
        repeat (40) cyc();
        check("pre_reset_repeating", int'(ifa.repeating), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pulse", int'(ifa.pulse), 0);
        check("async_rst_held", int'(ifa.held), 0);
        check("async_rst_repeating", int'(ifa.repeating), 0);
        repeat (3) cyc();
        rst_n = 1'b1;
        first = -1;
        for (int k = 1; k <= 20; k++) begin
            cyc();
            if (ifa.pulse[0] && first < 0) first = k;
        end
        check("post_reset_first_pulse", first, 6);
        btn = '0;
        repeat (20) cyc();

        // random buttons and tick enable, checked cycle by cycle
        en_div = 0;
        repeat (800) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 15) == 0) btn[c] = ~btn[c];
            end
            cyc();
        end
        en_div = 1;
        btn = '0;
        repeat (20) cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
